wave_record: RTL and testbench



---
 rtl/wave_pkg.sv | 27 ++
 rtl/wave_hdr_rom.sv | 42 ++++
 rtl/wave_record.sv | 218 +++++++++++++++++++++
 tb/tb_wave_record.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/wave_pkg.sv
// Shared types and constants for the RIFF/WAVE recorder.
package wave_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HDR     = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_FIXUP   = 3'd3,
        ST_DONE    = 3'd4
    } wave_state_t;

    localparam int HDR_LEN       = 44;
    localparam int RIFF_SIZE_OFS = 4;
    localparam int DATA_SIZE_OFS = 40;

    // Tags as written in text order: first character in the MSB.
    localparam logic [31:0] TAG_RIFF = "RIFF";
    localparam logic [31:0] TAG_WAVE = "WAVE";
    localparam logic [31:0] TAG_FMT  = "fmt ";
    localparam logic [31:0] TAG_DATA = "data";

    // Reorder a text tag so that byte 0 of the little-endian word is its first character.
    function automatic logic [31:0] tag_le(input logic [31:0] tag);
        return {tag[7:0], tag[15:8], tag[23:16], tag[31:24]};
    endfunction

endpackage

// File: rtl/wave_hdr_rom.sv
// Header byte generator: maps a header byte index and the latched
// configuration to the byte stored at that position of the 44-byte header.
// Size fields read as zero until sizes_final is raised during fixup.
module wave_hdr_rom
    import wave_pkg::*;
(
    input  logic [5:0]  idx,
    input  logic        bits16,
    input  logic [31:0] sample_rate,
    input  logic [31:0] data_size,
    input  logic        sizes_final,
    output logic [7:0]  hdr_byte
);

    logic [31:0] word;

    // Select the little-endian 32-bit word holding this byte, then the byte lane.
    always_comb begin
        word = 32'h0;
        case (idx[5:2])
            4'd0:  word = tag_le(TAG_RIFF);
            4'd1:  word = sizes_final ? (data_size + 32'd36) : 32'h0;
            4'd2:  word = tag_le(TAG_WAVE);
            4'd3:  word = tag_le(TAG_FMT);
            4'd4:  word = 32'd16;
            4'd5:  word = 32'h0001_0001;                       // PCM format, one channel
            4'd6:  word = sample_rate;
            4'd7:  word = bits16 ? {sample_rate[30:0], 1'b0} : sample_rate;
            4'd8:  word = bits16 ? 32'h0010_0002 : 32'h0008_0001; // bits, block_align
            4'd9:  word = tag_le(TAG_DATA);
            4'd10: word = sizes_final ? data_size : 32'h0;
            default: word = 32'h0;
        endcase
        case (idx[1:0])
            2'd0:    hdr_byte = word[7:0];
            2'd1:    hdr_byte = word[15:8];
            2'd2:    hdr_byte = word[23:16];
            default: hdr_byte = word[31:24];
        endcase
    end

endmodule

// File: rtl/wave_record.sv
// Records a signed 16-bit PCM stream as a mono RIFF/WAVE file into a
// byte-wide RAM, then back-fills the RIFF and data size fields.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for a rising edge on I_START
// HDR     | writing header bytes 0..43 with size placeholders
// CAPTURE | writing sample bytes behind the header
// FIXUP   | rewriting bytes 4..7 and 40..43 with the final sizes
// DONE    | one-cycle completion pulse, then back to IDLE
module wave_record
    import wave_pkg::*;
#(
    parameter int ADDR_W = 16
) (
    input  logic              I_CLK,
    input  logic              I_RSTn,
    input  logic              I_START,
    input  logic              I_STOP,
    input  logic              I_BITS16,
    input  logic [31:0]       I_SAMPLE_RATE,
    input  logic [ADDR_W-1:0] I_BASE_ADDR,
    input  logic [15:0]       I_MAX_LEN,
    input  logic [15:0]       I_SAMPLE,
    input  logic              I_SAMPLE_VALID,
    input  logic              I_WR_READY,
    output logic              O_WR_EN,
    output logic [ADDR_W-1:0] O_WR_ADDR,
    output logic [7:0]        O_WR_DATA,
    output logic              O_BUSY,
    output logic              O_DONE,
    output logic              O_OVERRUN,
    output logic [31:0]       O_DATA_SIZE
);

    wave_state_t       state;
    logic              start_d;
    logic              cfg_bits16;
    logic [31:0]       cfg_rate;
    logic [ADDR_W-1:0] cfg_base;
    logic [15:0]       cfg_max_len;
    logic [5:0]        hdr_idx;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic              hold_valid;
    logic              hold_hi;
    logic [7:0]        hold_msb;
    logic              stop_pend;
    logic [31:0]       data_size;
    logic              overrun;
    logic              done;

    logic              start_rise;
    logic              wr_acc;
    logic              last_acc;
    logic              hold_busy;
    logic [31:0]       cfg_bytes;
    logic [31:0]       size_commit;
    logic              over_limit;
    logic [7:0]        first_byte;
    logic [5:0]        rom_idx;
    logic [7:0]        rom_byte;

    assign start_rise = I_START & ~start_d;
    assign wr_acc     = wr_en & I_WR_READY;
    assign cfg_bytes  = cfg_bits16 ? 32'd2 : 32'd1;
    assign first_byte = cfg_bits16 ? I_SAMPLE[7:0] : (I_SAMPLE[15:8] ^ 8'h80);

    // Capture bookkeeping: a holding slot freed by this cycle's final byte may
    // be refilled in the same cycle, which gives back-to-back samples.
    always_comb begin
        last_acc    = wr_acc & (~cfg_bits16 | hold_hi);
        hold_busy   = hold_valid & ~last_acc;
        size_commit = data_size + {31'd0, wr_acc};
        over_limit  = (size_commit + cfg_bytes) > {16'd0, cfg_max_len};
    end

    // Header index presented next: advances on acceptance, and fixup jumps
    // from the end of the RIFF size field straight to the data size field.
    always_comb begin
        rom_idx = hdr_idx;
        if (wr_acc) begin
            if (state == ST_FIXUP && hdr_idx == 6'(RIFF_SIZE_OFS + 3))
                rom_idx = 6'(DATA_SIZE_OFS);
            else
                rom_idx = hdr_idx + 6'd1;
        end
    end

    wave_hdr_rom u_hdr_rom (
        .idx         (rom_idx),
        .bits16      (cfg_bits16),
        .sample_rate (cfg_rate),
        .data_size   (data_size),
        .sizes_final (state == ST_FIXUP),
        .hdr_byte    (rom_byte)
    );

    // Recorder FSM with registered write port and status outputs.
    always_ff @(posedge I_CLK or negedge I_RSTn) begin
        if (!I_RSTn) begin
            state       <= ST_IDLE;
            start_d     <= 1'b0;
            cfg_bits16  <= 1'b0;
            cfg_rate    <= '0;
            cfg_base    <= '0;
            cfg_max_len <= '0;
            hdr_idx     <= '0;
            wr_en       <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= '0;
            hold_valid  <= 1'b0;
            hold_hi     <= 1'b0;
            hold_msb    <= '0;
            stop_pend   <= 1'b0;
            data_size   <= '0;
            overrun     <= 1'b0;
            done        <= 1'b0;
        end else begin
            start_d <= I_START;
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start_rise) begin
                        cfg_bits16  <= I_BITS16;
                        cfg_rate    <= I_SAMPLE_RATE;
                        cfg_base    <= I_BASE_ADDR;
                        cfg_max_len <= I_MAX_LEN;
                        data_size   <= '0;
                        overrun     <= 1'b0;
                        hdr_idx     <= '0;
                        hold_valid  <= 1'b0;
                        hold_hi     <= 1'b0;
                        stop_pend   <= 1'b0;
                        state       <= ST_HDR;
                    end
                end

                ST_HDR, ST_FIXUP: begin
                    if (!wr_en) begin
                        wr_en   <= 1'b1;
                        wr_addr <= cfg_base + ADDR_W'(hdr_idx);
                        wr_data <= rom_byte;
                    end else if (I_WR_READY) begin
                        if (hdr_idx == 6'(HDR_LEN - 1)) begin
                            wr_en <= 1'b0;
                            if (state == ST_HDR) begin
                                state <= ST_CAPTURE;
                            end else begin
                                state <= ST_DONE;
                                done  <= 1'b1;
                            end
                        end else begin
                            hdr_idx <= rom_idx;
                            wr_addr <= cfg_base + ADDR_W'(rom_idx);
                            wr_data <= rom_byte;
                        end
                    end
                end

                ST_CAPTURE: begin
                    if (wr_acc)
                        data_size <= data_size + 32'd1;
                    if (wr_acc && !last_acc) begin
                        hold_hi <= 1'b1;
                        wr_addr <= wr_addr + ADDR_W'(1);
                        wr_data <= hold_msb;
                    end
                    if (last_acc) begin
                        hold_valid <= 1'b0;
                        hold_hi    <= 1'b0;
                        wr_en      <= 1'b0;
                    end
                    if (I_STOP || stop_pend) begin
                        if (!hold_busy) begin
                            stop_pend <= 1'b0;
                            hdr_idx   <= 6'(RIFF_SIZE_OFS);
                            state     <= ST_FIXUP;
                        end else begin
                            stop_pend <= 1'b1;
                        end
                    end else if (I_SAMPLE_VALID) begin
                        if (hold_busy) begin
                            overrun <= 1'b1;
                        end else if (over_limit) begin
                            hdr_idx <= 6'(RIFF_SIZE_OFS);
                            state   <= ST_FIXUP;
                        end else begin
                            hold_valid <= 1'b1;
                            hold_hi    <= 1'b0;
                            hold_msb   <= I_SAMPLE[15:8];
                            wr_en      <= 1'b1;
                            wr_addr    <= cfg_base + ADDR_W'(HDR_LEN) + size_commit[ADDR_W-1:0];
                            wr_data    <= first_byte;
                        end
                    end
                end

                ST_DONE: begin
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

    assign O_WR_EN     = wr_en;
    assign O_WR_ADDR   = wr_addr;
    assign O_WR_DATA   = wr_data;
    assign O_BUSY      = (state != ST_IDLE);
    assign O_DONE      = done;
    assign O_OVERRUN   = overrun;
    assign O_DATA_SIZE = data_size;

endmodule

// File: tb/tb_wave_record.sv
// Directed bench for wave_record with a behavioural byte RAM.
module tb_wave_record;

    logic        I_CLK = 1'b0;
    logic        I_RSTn = 1'b0;
    logic        I_START = 1'b0;
    logic        I_STOP = 1'b0;
    logic        I_BITS16 = 1'b0;
    logic [31:0] I_SAMPLE_RATE = '0;
    logic [15:0] I_BASE_ADDR = '0;
    logic [15:0] I_MAX_LEN = '0;
    logic [15:0] I_SAMPLE = '0;
    logic        I_SAMPLE_VALID = 1'b0;
    logic        I_WR_READY = 1'b1;
    logic        O_WR_EN;
    logic [15:0] O_WR_ADDR;
    logic [7:0]  O_WR_DATA;
    logic        O_BUSY;
    logic        O_DONE;
    logic        O_OVERRUN;
    logic [31:0] O_DATA_SIZE;

    logic [7:0]  ram [0:65535];
    logic [15:0] wr_log [0:4095];
    logic        ram_clr = 1'b1;
    int          n_wr = 0;
    int          done_cnt = 0;
    int          n_chk = 0;
    int          n_pass = 0;

    wave_record #(.ADDR_W(16)) dut (
        .I_CLK          (I_CLK),
        .I_RSTn         (I_RSTn),
        .I_START        (I_START),
        .I_STOP         (I_STOP),
        .I_BITS16       (I_BITS16),
        .I_SAMPLE_RATE  (I_SAMPLE_RATE),
        .I_BASE_ADDR    (I_BASE_ADDR),
        .I_MAX_LEN      (I_MAX_LEN),
        .I_SAMPLE       (I_SAMPLE),
        .I_SAMPLE_VALID (I_SAMPLE_VALID),
        .I_WR_READY     (I_WR_READY),
        .O_WR_EN        (O_WR_EN),
        .O_WR_ADDR      (O_WR_ADDR),
        .O_WR_DATA      (O_WR_DATA),
        .O_BUSY         (O_BUSY),
        .O_DONE         (O_DONE),
        .O_OVERRUN      (O_OVERRUN),
        .O_DATA_SIZE    (O_DATA_SIZE)
    );

    always #5 I_CLK = ~I_CLK;

    // Byte RAM, write log and completion pulse counter.
    always @(posedge I_CLK) begin
        if (ram_clr) begin
            for (int i = 0; i < 65536; i++) ram[i] <= 8'hEE;
        end else if (O_WR_EN && I_WR_READY) begin
            ram[O_WR_ADDR] <= O_WR_DATA;
            wr_log[n_wr]   <= O_WR_ADDR;
            n_wr           <= n_wr + 1;
        end
        if (O_DONE) done_cnt <= done_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Four bytes in file order, first byte in the MSB.
    function automatic logic [31:0] ram4(input logic [15:0] a);
        return {ram[a], ram[a + 16'd1], ram[a + 16'd2], ram[a + 16'd3]};
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge I_CLK);
        #1;
    endtask

    task automatic start_rec(input logic b16, input logic [31:0] rate,
                             input logic [15:0] base, input logic [15:0] maxl);
        I_BITS16 = b16;
        I_SAMPLE_RATE = rate;
        I_BASE_ADDR = base;
        I_MAX_LEN = maxl;
        I_START = 1'b1;
        tick(1);
        I_START = 1'b0;
    endtask

    task automatic wait_wr(input int target, input string tag);
        int k;
        k = 0;
        while (n_wr < target && k < 300) begin
            tick(1);
            k++;
        end
        chk(tag, 32'(n_wr >= target), 32'd1);
    endtask

    task automatic wait_done(input int d0, input string tag);
        int k;
        k = 0;
        while (done_cnt <= d0 && k < 200) begin
            tick(1);
            k++;
        end
        chk(tag, 32'(done_cnt > d0), 32'd1);
    endtask

    task automatic send(input logic [15:0] s);
        I_SAMPLE = s;
        I_SAMPLE_VALID = 1'b1;
        tick(1);
        I_SAMPLE_VALID = 1'b0;
        tick(2);
    endtask

    task automatic finish_rec(input string tag);
        int d0;
        d0 = done_cnt;
        I_STOP = 1'b1;
        wait_done(d0, tag);
        I_STOP = 1'b0;
        tick(3);
        chk({tag, "_one_done"}, 32'(done_cnt), 32'(d0 + 1));
        chk({tag, "_idle"}, 32'(O_BUSY), 32'd0);
    endtask

    initial begin
        int n0;
        int d0;

        // reset
        tick(2);
        chk("rst_outputs", {O_WR_EN, O_BUSY, O_DONE, O_OVERRUN, O_WR_ADDR, O_WR_DATA}, 32'd0);
        chk("rst_size", O_DATA_SIZE, 32'd0);
        ram_clr = 1'b0;
        I_RSTn = 1'b1;
        tick(2);

        // 16-bit, 11025 Hz, three samples then stop
        start_rec(1'b1, 32'd11025, 16'h0100, 16'hFFFF);
        wait_wr(44, "t1_hdr");
        send(16'h1234);
        send(16'hFFFE);
        send(16'h0001);
        finish_rec("t1");
        chk("t1_riff", ram4(16'h0100), 32'h52494646);
        chk("t1_wave", ram4(16'h0108), 32'h57415645);
        chk("t1_fmtlen", ram4(16'h0110), 32'h10000000);
        chk("t1_fmt_ch", ram4(16'h0114), 32'h01000100);
        chk("t1_rate", ram4(16'h0118), 32'h112B0000);
        chk("t1_byterate", ram4(16'h011C), 32'h22560000);
        chk("t1_align_bits", ram4(16'h0120), 32'h02001000);
        chk("t1_datatag", ram4(16'h0124), 32'h64617461);
        chk("t1_data0", ram4(16'h012C), 32'h3412FEFF);
        chk("t1_data1", ram4(16'h0130), 32'h0100EEEE);
        chk("t1_riffsize", ram4(16'h0104), 32'h2A000000);
        chk("t1_datasize", ram4(16'h0128), 32'h06000000);
        chk("t1_size_out", O_DATA_SIZE, 32'd6);
        chk("t1_overrun", 32'(O_OVERRUN), 32'd0);

        // 8-bit offset-binary conversion
        n0 = n_wr;
        start_rec(1'b0, 32'd8000, 16'h0200, 16'hFFFF);
        wait_wr(n0 + 44, "t2_hdr");
        send(16'h8000);
        send(16'h0000);
        send(16'h7FFF);
        finish_rec("t2");
        chk("t2_data", ram4(16'h022C), 32'h0080FFEE);
        chk("t2_align_bits", ram4(16'h0220), 32'h01000800);
        chk("t2_byterate", ram4(16'h021C), 32'h401F0000);
        chk("t2_datasize", ram4(16'h0228), 32'h03000000);
        chk("t2_riffsize", ram4(16'h0204), 32'h27000000);
        chk("t2_size_out", O_DATA_SIZE, 32'd3);

        // odd length limit in 16-bit mode ends capture after two samples
        n0 = n_wr;
        d0 = done_cnt;
        start_rec(1'b1, 32'd44100, 16'h0400, 16'd5);
        wait_wr(n0 + 44, "t3_hdr");
        for (int i = 0; i < 6; i++) begin
            I_SAMPLE = 16'(16'h1111 * (i + 1));
            I_SAMPLE_VALID = 1'b1;
            tick(1);
            I_SAMPLE_VALID = 1'b0;
            tick(1);
        end
        wait_done(d0, "t3_autodone");
        tick(2);
        chk("t3_data", ram4(16'h042C), 32'h11112222);
        chk("t3_no_extra", 32'(ram[16'h0430]), 32'h000000EE);
        chk("t3_datasize", ram4(16'h0428), 32'h04000000);
        chk("t3_riffsize", ram4(16'h0404), 32'h28000000);
        chk("t3_size_out", O_DATA_SIZE, 32'd4);
        chk("t3_writes", 32'(n_wr - n0), 32'd56);
        chk("t3_overrun", 32'(O_OVERRUN), 32'd0);

        // write stall with strobes every other cycle
        n0 = n_wr;
        start_rec(1'b1, 32'd16000, 16'h0800, 16'hFFFF);
        wait_wr(n0 + 44, "t4_hdr");
        I_WR_READY = 1'b0;
        for (int i = 0; i < 5; i++) begin
            I_SAMPLE_VALID = (i % 2 == 0);
            I_SAMPLE = (i == 0) ? 16'hA1B2 : (i == 2) ? 16'h5555 : 16'h6666;
            tick(1);
            chk("t4_stall_hold", {7'd0, O_WR_EN, O_WR_ADDR, O_WR_DATA}, {8'h01, 16'h082C, 8'hB2});
        end
        I_SAMPLE_VALID = 1'b0;
        I_WR_READY = 1'b1;
        tick(3);
        chk("t4_overrun", 32'(O_OVERRUN), 32'd1);
        send(16'hC3D4);
        finish_rec("t4");
        chk("t4_data", ram4(16'h082C), 32'hB2A1D4C3);
        chk("t4_no_extra", 32'(ram[16'h0830]), 32'h000000EE);
        chk("t4_writes", 32'(n_wr - n0), 32'd56);
        chk("t4_size_out", O_DATA_SIZE, 32'd4);

        // address wrap
        n0 = n_wr;
        start_rec(1'b1, 32'd48000, 16'hFFF0, 16'hFFFF);
        wait_wr(n0 + 44, "t5_hdr");
        chk("t5_wrap_addr", 32'(wr_log[n0 + 16]), 32'h00000000);
        chk("t5_fmt_tag", ram4(16'hFFFC), 32'h666D7420);
        chk("t5_wrap_byte", ram4(16'h0000), 32'h10000000);
        finish_rec("t5");
        chk("t5_riffsize", ram4(16'hFFF4), 32'h24000000);
        chk("t5_datasize", ram4(16'h0018), 32'h00000000);

        // reset during header, restart, ignored start during capture
        n0 = n_wr;
        start_rec(1'b1, 32'd11025, 16'h0A00, 16'hFFFF);
        wait_wr(n0 + 10, "t6_partial");
        I_RSTn = 1'b0;
        #2;
        chk("t6_rst_outputs", {O_WR_EN, O_BUSY, O_DONE, O_OVERRUN, O_WR_ADDR, O_WR_DATA}, 32'd0);
        chk("t6_rst_size", O_DATA_SIZE, 32'd0);
        tick(2);
        I_RSTn = 1'b1;
        tick(1);
        n0 = n_wr;
        start_rec(1'b1, 32'd11025, 16'h0A00, 16'hFFFF);
        wait_wr(n0 + 44, "t6_hdr");
        chk("t6_first_addr", 32'(wr_log[n0]), 32'h00000A00);
        chk("t6_last_addr", 32'(wr_log[n0 + 43]), 32'h00000A2B);
        send(16'h7788);
        I_START = 1'b1;
        tick(1);
        I_START = 1'b0;
        tick(3);
        chk("t6_start_ignored", {O_BUSY, O_DATA_SIZE[30:0]}, {1'b1, 31'd2});
        chk("t6_no_rewrite", 32'(n_wr - n0), 32'd46);
        finish_rec("t6");
        chk("t6_data", ram4(16'h0A2C), 32'h8877EEEE);
        chk("t6_datasize", ram4(16'h0A28), 32'h02000000);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
